pwm_multi_ch: RTL
=================

// Module: pwm_multi_ch
// PURPOSE
//   N-channel PWM generator sharing one period counter, with edge- or centre-aligned
//   mode, per-channel output inversion and double-buffered period/duty updates.
//   Updates land only at a period boundary, so no glitched or truncated pulses.
//   Drives motor/LED stages. Control comes from a CPU-side register block or an FSM.
// PARAMETERS
//   CH    4      number of output channels
//   W     8      counter/period/duty width in bits
//   INV   '0     CH-bit mask: 1 = channel output is active-low
// PORTS
//   clk          in   1      system clock
//   rst_n        in   1      asynchronous active-low reset
//   en           in   1      1 = run counter; 0 = hold at 0, outputs inactive
//   align        in   1      pwm_pkg::align_e: 0 EDGE, 1 CENTER (sampled at boundary)
//   period_i     in   W      staged period value
//   duty_i       in   CH*W   staged duty per channel, ch k at [k*W +: W]
//   upd_req      in   1      1-cycle strobe: capture period_i/duty_i/align into staging
//   upd_pending  out  1      staged values not yet applied
//   upd_done     out  1      1-cycle pulse on the cycle the staged values are applied
//   cyc_start    out  1      1-cycle pulse when the counter is at 0 (period boundary)
//   pwm_o        out  CH     PWM outputs, registered
// BEHAVIOUR
//   Reset: cnt=0, dir=up, active period/duty/align=0, staging=0, upd_pending=0,
//     upd_done=0, cyc_start=0, pwm_o=INV (all channels at inactive level).
//   Counter, EDGE: 0,1,..,P,0,... Period is P+1 clocks.
//   Counter, CENTER: 0,1,..,P,P-1,..,1,0,... Period is 2P clocks. dir flips at P and at 0.
//   P=0 in either mode: cnt stays 0. Every cycle is a boundary.
//   Boundary = the cycle cnt==0 and en=1. cyc_start is asserted on that cycle.
//   Compare: act_k = (cnt < D_k). pwm_o[k] <= act_k ^ INV[k]. One cycle latency from cnt.
//     D_k=0 gives always inactive. D_k>P gives always active (EDGE), or active over the full
//     2P period (CENTER). Centre pulse width = 2*D_k clocks, symmetric about cnt==0.
//   Staging: upd_req writes period_i/duty_i/align into staging and sets upd_pending next cycle.
//     A further upd_req while pending overwrites the staging; the last write wins.
//   Apply: if upd_pending=1 at a boundary, active <= staging and upd_pending <= 0.
//     upd_done pulses on that same edge. The new values govern the compare on the next
//     cycle (cnt==1).
//     If upd_req and the apply happen in the same cycle, the apply uses the old staging.
//     The new request is then captured and pending stays 1.
//   en=0: cnt forced to 0 and dir set to up. pwm_o <= INV. cyc_start=0.
//     Any pending update applies on the first cycle with en=0, and upd_done pulses.
//   en rising: the first cycle with en=1 is a boundary (cnt==0).
//   Mode change is applied only at a boundary; the counter always restarts at 0 counting up.
//   Asynchronous reset mid-period: all state returns immediately to the reset values above.
// STRUCTURE
//   pwm_pkg: typedef enum logic {EDGE, CENTER} align_e;
//     localparam-free helper function dmax(W) = 2**W-1.
//   Sub-module pwm_cmp (one per channel, generate loop): registered compare
//     plus inversion. It takes cnt, D_k, INV[k] and en.
//   Top level holds the counter, direction FSM (UP/DOWN), staging/apply logic and the
//     cyc_start/upd_done pulses.
// TESTING (clk via SimSrcGen::GenClk 10ns; rst_n low 5 cycles)
//   1. Reset: rst_n=0 -> pwm_o==INV, upd_pending=0. Counter stays at 0.
//   2. EDGE, P=9, D0=3, D1=0, D2=10, INV=0:
//      ch0 high 3 of every 10 clks, ch1 always 0, ch2 always 1. cyc_start every 10 clks.
//   3. CENTER, P=8, D0=2: period 16 clks. ch0 high 4 clks centred on cnt==0.
//      cyc_start every 16 clks.
//   4. Mid-period update (D0 3->7 issued at cnt==5):
//      upd_pending=1 until the next cnt==0. upd_done pulses then.
//      The current period keeps its 3-clk pulse; the next period has a 7-clk pulse.
//   5. Two upd_req in one period (D0=4, then D0=6):
//      only D0=6 is applied, with a single upd_done.
//   6. en=0 mid-pulse with INV[0]=1: pwm_o[0]=1 next cycle and cnt=0.
//      Pending update applied. Re-enable: cyc_start on the first en=1 cycle.
//      Assert rst_n=0 mid-period -> immediate reset values.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {EDGE, CENTER} align_e;
  typedef enum logic {UP, DOWN} dir_e;

  // Largest value representable in a w-bit duty/period field.
  function automatic int dmax(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/pwm_cmp.sv
// One PWM channel: registered duty compare with output polarity select.
module pwm_cmp
  import pwm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] duty,
  input  logic         inv,
  input  logic         en,
  input  logic         late,
  output logic         pwm
);

  logic act;

  // On the falling half of a centre-aligned period cnt==duty also counts,
  // which makes the pulse exactly 2*duty clocks wide.
  assign act = (cnt < duty) | (late & (cnt <= duty));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= inv;
    end else if (!en) begin
      pwm <= inv;
    end else begin
      pwm <= act ^ inv;
    end
  end

endmodule

// File: rtl/pwm_multi_ch.sv
// N-channel PWM with a shared period counter, edge/centre alignment and
// double-buffered period/duty/alignment that only take effect at a period boundary.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int            CH  = 4,
  parameter int            W   = 8,
  parameter logic [CH-1:0] INV = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            align,
  input  logic [W-1:0]    period_i,
  input  logic [CH*W-1:0] duty_i,
  input  logic            upd_req,
  output logic            upd_pending,
  output logic            upd_done,
  output logic            cyc_start,
  output logic [CH-1:0]   pwm_o
);

  logic [W-1:0]    cnt;
  dir_e            dir;
  logic [W-1:0]    act_p, stg_p;
  align_e          act_al, stg_al;
  logic [CH*W-1:0] act_d, stg_d;
  logic            at_zero, apply, late;
  logic [W-1:0]    eff_p;

  assign at_zero   = (cnt == '0);
  assign apply     = upd_pending & (~en | at_zero);
  assign eff_p     = apply ? stg_p : act_p;
  assign cyc_start = rst_n & en & at_zero;

  // Second half of a centre period, including the turn-around cell at cnt==P.
  assign late = (act_al == CENTER) & ~at_zero & ((dir == DOWN) | (cnt == act_p));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      dir <= UP;
    end else if (!en) begin
      cnt <= '0;
      dir <= UP;
    end else if (at_zero) begin
      // Boundary: restart upward under whatever period is in force from now on.
      dir <= UP;
      cnt <= (eff_p == '0) ? '0 : W'(1);
    end else if (act_al == EDGE) begin
      cnt <= (cnt >= act_p) ? '0 : cnt + W'(1);
    end else begin
      case (dir)
        UP: begin
          if (cnt >= act_p) begin
            cnt <= cnt - W'(1);
            dir <= DOWN;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        DOWN: cnt <= cnt - W'(1);
        default: begin
          cnt <= '0;
          dir <= UP;
        end
      endcase
    end
  end

  // A request in the same cycle as an apply lands in staging after the old
  // staging has been consumed, so it stays pending for the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_p       <= '0;
      act_al      <= EDGE;
      act_d       <= '0;
      stg_p       <= '0;
      stg_al      <= EDGE;
      stg_d       <= '0;
      upd_pending <= 1'b0;
      upd_done    <= 1'b0;
    end else begin
      upd_done <= apply;
      if (apply) begin
        act_p  <= stg_p;
        act_al <= stg_al;
        act_d  <= stg_d;
      end
      if (upd_req) begin
        stg_p       <= period_i;
        stg_al      <= align_e'(align);
        stg_d       <= duty_i;
        upd_pending <= 1'b1;
      end else if (apply) begin
        upd_pending <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    pwm_cmp #(.W(W)) u_cmp (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt   (cnt),
      .duty  (act_d[k*W +: W]),
      .inv   (INV[k]),
      .en    (en),
      .late  (late),
      .pwm   (pwm_o[k])
    );
  end

endmodule
